// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Brief    : Program counter with jump/branch/call/return and a return-address
//            stack, sticky overflow/underflow/misalignment flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer #(
  parameter int               WIDTH     = 16,
  parameter int               STEP      = 2,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             jump_to,
  input  logic                             branch,
  input  logic                             call,
  input  logic                             ret,
  input  logic [WIDTH-1:0]                 cin,
  input  logic                             err_clr,
  output logic [WIDTH-1:0]                 cout,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
  output logic                             ras_full,
  output logic                             ras_empty,
  output logic                             ovf_err,
  output logic                             unf_err,
  output logic                             mis_err
);

  localparam int               CW         = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] STEP_W     = WIDTH'(STEP);
  // Low target bits that must be zero; an all-zero mask disables the check when STEP=1.
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
  localparam logic [CW-1:0]    DEPTH_C    = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             mis_q, mis_d;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];
  logic [WIDTH-1:0] stack_d [RAS_DEPTH];

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] tgt;
  logic             use_tgt;
  logic             full;
  logic             empty;

  assign full   = (count_q == DEPTH_C);
  assign empty  = (count_q == '0);
  assign seq_pc = pc_q + STEP_W;

  always_comb begin
    top = '0;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      if (CW'(i + 1) == count_q) top = stack_q[i];
    end
  end

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    stack_d = stack_q;
    tgt     = '0;
    use_tgt = 1'b0;
    ovf_d   = ovf_q & ~err_clr;
    unf_d   = unf_q & ~err_clr;
    mis_d   = mis_q & ~err_clr;

    if (!stall) begin
      if (ret) begin
        if (empty) begin
          pc_d  = seq_pc;
          unf_d = 1'b1;
        end else begin
          tgt     = top;
          use_tgt = 1'b1;
          count_d = count_q - CW'(1);
        end
      end else if (call) begin
        tgt     = cin;
        use_tgt = 1'b1;
        if (full) begin
          // Oldest entry sits at index 0; shift it out to make room at the top.
          for (int i = 0; i < RAS_DEPTH - 1; i++) stack_d[i] = stack_q[i+1];
          stack_d[RAS_DEPTH-1] = seq_pc;
          ovf_d = 1'b1;
        end else begin
          for (int i = 0; i < RAS_DEPTH; i++) begin
            if (CW'(i) == count_q) stack_d[i] = seq_pc;
          end
          count_d = count_q + CW'(1);
        end
      end else if (jump_to) begin
        tgt     = cin;
        use_tgt = 1'b1;
      end else if (branch) begin
        tgt     = pc_q + cin;
        use_tgt = 1'b1;
      end else begin
        pc_d = seq_pc;
      end

      if (use_tgt) begin
        pc_d = tgt & ~ALIGN_MASK;
        if ((tgt & ALIGN_MASK) != '0) mis_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      mis_q   <= mis_d;
    end
  end

  // Entry contents are qualified by count_q, so they need no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign cout      = pc_q;
  assign ras_count = count_q;
  assign ras_full  = full;
  assign ras_empty = empty;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;
  assign mis_err   = mis_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module   : tb_pc_sequencer
// Brief    : Scoreboard bench for pc_sequencer with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  typedef struct packed {
    logic [15:0] pc;
    logic [2:0]  cnt;
    logic        full;
    logic        empty;
    logic        ovf;
    logic        unf;
    logic        mis;
  } exp_t;

  localparam logic [5:0] I = 6'b000000;
  localparam logic [5:0] S = 6'b100000;
  localparam logic [5:0] R = 6'b010000;
  localparam logic [5:0] C = 6'b001000;
  localparam logic [5:0] J = 6'b000100;
  localparam logic [5:0] B = 6'b000010;
  localparam logic [5:0] E = 6'b000001;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump_to = 1'b0;
  logic        branch = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        err_clr = 1'b0;
  logic [15:0] cin = '0;
  logic [15:0] cout;
  logic [2:0]  ras_count;
  logic        ras_full, ras_empty, ovf_err, unf_err, mis_err;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_pass = 0;

  pc_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .jump_to   (jump_to),
    .branch    (branch),
    .call      (call),
    .ret       (ret),
    .cin       (cin),
    .err_clr   (err_clr),
    .cout      (cout),
    .ras_count (ras_count),
    .ras_full  (ras_full),
    .ras_empty (ras_empty),
    .ovf_err   (ovf_err),
    .unf_err   (unf_err),
    .mis_err   (mis_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] pc, input logic [2:0] cnt, input logic [2:0] flg);
    mk = {pc, cnt, (cnt == 3'd4), (cnt == 3'd0), flg};
  endfunction

  // Monitor: every rising edge or asynchronous reset assertion produces a new output state.
  initial begin
    exp_t  e;
    exp_t  act;
    string nm;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = {cout, ras_count, ras_full, ras_empty, ovf_err, unf_err, mis_err};
        n_checks++;
        if (act === e) n_pass++;
        else $display("FAIL %s: got pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b mis=%b, expected pc=%h cnt=%0d full=%b empty=%b ovf=%b unf=%b mis=%b",
                      nm, act.pc, act.cnt, act.full, act.empty, act.ovf, act.unf, act.mis,
                      e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf, e.mis);
      end
    end
  end

  task automatic drv(input logic [5:0] ctl, input logic [15:0] ci, input logic [15:0] epc,
                     input logic [2:0] ecnt, input logic [2:0] eflg, input string nm);
    @(negedge clk);
    {stall, ret, call, jump_to, branch, err_clr} = ctl;
    cin = ci;
    exp_q.push_back(mk(epc, ecnt, eflg));
    name_q.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset state
    #2;
    exp_q.push_back(mk(16'h0000, 3'd0, 3'b000));
    name_q.push_back("reset_state");
    reset = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;

    // Sequential increments
    drv(I, 16'h0000, 16'h0002, 3'd0, 3'b000, "seq1");
    drv(I, 16'h0000, 16'h0004, 3'd0, 3'b000, "seq2");
    drv(I, 16'h0000, 16'h0006, 3'd0, 3'b000, "seq3");
    drv(I, 16'h0000, 16'h0008, 3'd0, 3'b000, "seq4");

    // Call / return
    drv(J, 16'h0010, 16'h0010, 3'd0, 3'b000, "jump_0010");
    drv(C, 16'h0100, 16'h0100, 3'd1, 3'b000, "call_0100");
    drv(R, 16'h0000, 16'h0012, 3'd0, 3'b000, "ret_0012");

    // Negative branch and wrap-around
    drv(J, 16'h0100, 16'h0100, 3'd0, 3'b000, "jump_0100");
    drv(B, 16'hFFF0, 16'h00F0, 3'd0, 3'b000, "branch_neg");
    drv(J, 16'hFFFE, 16'hFFFE, 3'd0, 3'b000, "jump_FFFE");
    drv(I, 16'h0000, 16'h0000, 3'd0, 3'b000, "seq_wrap");

    // Nested calls with overflow, then returns and underflow
    drv(C, 16'h0100, 16'h0100, 3'd1, 3'b000, "ncall1");
    drv(C, 16'h0200, 16'h0200, 3'd2, 3'b000, "ncall2");
    drv(C, 16'h0300, 16'h0300, 3'd3, 3'b000, "ncall3");
    drv(C, 16'h0400, 16'h0400, 3'd4, 3'b000, "ncall4_full");
    drv(C, 16'h0500, 16'h0500, 3'd4, 3'b100, "ncall5_ovf");
    drv(R, 16'h0000, 16'h0402, 3'd3, 3'b100, "nret1");
    drv(R, 16'h0000, 16'h0302, 3'd2, 3'b100, "nret2");
    drv(R, 16'h0000, 16'h0202, 3'd1, 3'b100, "nret3");
    drv(R, 16'h0000, 16'h0102, 3'd0, 3'b100, "nret4");
    drv(R, 16'h0000, 16'h0104, 3'd0, 3'b110, "nret5_unf");
    drv(E, 16'h0000, 16'h0106, 3'd0, 3'b000, "err_clr");

    // Priority
    drv(C,         16'h0200, 16'h0200, 3'd1, 3'b000, "call_0200");
    drv(R | C,     16'h0300, 16'h0108, 3'd0, 3'b000, "ret_over_call");
    drv(C | J | B, 16'h0400, 16'h0400, 3'd1, 3'b000, "call_over_jump");
    drv(J | B,     16'h0010, 16'h0010, 3'd1, 3'b000, "jump_over_branch");

    // Misalignment, stall, err_clr
    drv(J,     16'h0033, 16'h0032, 3'd1, 3'b001, "jump_mis");
    drv(E,     16'h0000, 16'h0034, 3'd1, 3'b000, "clr_mis");
    drv(S | J, 16'h1000, 16'h0034, 3'd1, 3'b000, "stall1");
    drv(S | J, 16'h1000, 16'h0034, 3'd1, 3'b000, "stall2");
    drv(S | J, 16'h1000, 16'h0034, 3'd1, 3'b000, "stall3");
    drv(J,     16'h0035, 16'h0034, 3'd1, 3'b001, "jump_mis2");
    drv(S | E, 16'h0000, 16'h0034, 3'd1, 3'b000, "stall_clr");
    drv(E | J, 16'h0037, 16'h0036, 3'd1, 3'b001, "set_wins");
    drv(S | R, 16'h0000, 16'h0036, 3'd1, 3'b001, "stall_ret");
    drv(R,     16'h0000, 16'h010A, 3'd0, 3'b001, "ret_010A");
    drv(B,     16'h0003, 16'h010C, 3'd0, 3'b001, "branch_mis");
    drv(E,     16'h0000, 16'h010E, 3'd0, 3'b000, "clr_all");

    // Asynchronous reset in the middle of a call
    drv(C, 16'h0200, 16'h0200, 3'd1, 3'b000, "call_pre_rst");
    @(negedge clk);
    {stall, ret, call, jump_to, branch, err_clr} = C;
    cin = 16'h0300;
    #2;
    exp_q.push_back(mk(16'h0000, 3'd0, 3'b000));
    name_q.push_back("async_reset");
    reset = 1'b0;
    @(negedge clk);
    {stall, ret, call, jump_to, branch, err_clr} = I;
    cin = '0;
    @(posedge clk);
    #2 reset = 1'b1;
    drv(I, 16'h0000, 16'h0002, 3'd0, 3'b000, "post_rst_seq");
    drv(R, 16'h0000, 16'h0004, 3'd0, 3'b010, "post_rst_ret_empty");

    @(negedge clk);
    {stall, ret, call, jump_to, branch, err_clr} = I;
    @(posedge clk);
    #3;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
